fifo_wr_arb: RTL and testbench
==============================

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (2..8).
REQ-002 Parameter FIFO_WIDTH, default 16, data width per requester and at the FIFO write port.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant (1..15).
REQ-004 Port clk, input, 1, single clock; all state SHALL change on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port req, input, NUM_REQ, per-requester write request, held until granted.
REQ-007 Port last, input, NUM_REQ, per-requester end-of-burst marker, qualified by req.
REQ-008 Port data_in, input, NUM_REQ*FIFO_WIDTH, flattened requester data; slice i = requester i.
REQ-009 Port gnt, output, NUM_REQ, one-hot grant; one beat is accepted per cycle gnt[i]=1.
REQ-010 Port fifo_full, input, 1, FIFO full flag.
REQ-011 Port fifo_overflow, input, 1, FIFO overflow flag.
REQ-012 Port fifo_wr_en, output, 1, FIFO write enable.
REQ-013 Port fifo_data_in, output, FIFO_WIDTH, FIFO write data.
REQ-014 Port owner, output, $clog2(NUM_REQ), index of the locked requester; valid while busy=1.
REQ-015 Port busy, output, 1, high in state BURST.
REQ-016 Port err_ovf, output, 1, sticky overflow error.
REQ-017 Port grant_cnt, output, NUM_REQ*16, flattened per-requester grant counters.

Function
REQ-018 FSM SHALL have two states: ARB (no owner) and BURST (owner locked); rr_ptr SHALL be a registered round-robin pointer.
REQ-019 In ARB with fifo_full=0 and req!=0, the arbiter SHALL grant the first set req at or after rr_ptr, wrapping NUM_REQ-1 to 0, in the same cycle (zero latency).
REQ-020 fifo_wr_en SHALL equal |gnt; fifo_data_in SHALL equal the granted slice of data_in, or 0 when gnt=0.
REQ-021 fifo_full=1 SHALL force gnt=0 in any state, including a stall inside BURST.
REQ-022 In ARB, a grant with last=0 and MAX_BURST>1 SHALL move to BURST with owner=winner and beat_cnt=1; otherwise the FSM SHALL stay in ARB.
REQ-023 In BURST, only the owner SHALL be granted; each granted beat SHALL increment beat_cnt.
REQ-024 BURST SHALL return to ARB after a granted beat with last=1, after the beat that makes beat_cnt=MAX_BURST, or in any cycle where req[owner]=0.
REQ-025 On every return to ARB and on every single-beat ARB grant, rr_ptr SHALL load (granted or owner index + 1) mod NUM_REQ.
REQ-026 err_ovf SHALL set on any rising edge with fifo_overflow=1 and SHALL clear only on reset.
REQ-027 last SHALL be ignored in a cycle when the requester is not granted.

Reset
REQ-028 While rst_n=0: state=ARB, rr_ptr=0, beat_cnt=0, owner=0, busy=0, err_ovf=0, grant_cnt=0, and gnt=0, fifo_wr_en=0, fifo_data_in=0 regardless of req.
REQ-029 Reset asserted mid-burst SHALL abort the burst immediately; after release, arbitration SHALL restart from requester 0.

Configuration
REQ-030 With macro FIFO_WR_ARB_STATS_EN defined, grant_cnt slice i SHALL increment by one per granted beat of requester i and SHALL saturate at 16'hFFFF.
REQ-031 Without FIFO_WR_ARB_STATS_EN, grant_cnt SHALL be constant 0 and no counter registers SHALL be built.

Verification
REQ-032 Fairness: NUM_REQ=4, req=4'b1111, last=4'b1111, fifo_full=0 -> gnt sequence 0001,0010,0100,1000,0001.
REQ-033 Burst cap: MAX_BURST=4, req[2] held with last=0, req[0]=1 -> four beats to 2 (busy=1, owner=2), then gnt=0001.
REQ-034 Full stall: in BURST with owner=1 at beat 2, fifo_full=1 for 3 cycles -> gnt=0, fifo_wr_en=0, busy=1; after fifo_full drops, beats resume at beat 3.
REQ-035 Early release: owner 3 drops req mid-burst with req[1]=1 -> next cycle busy=0 and gnt=0010.
REQ-036 Reset mid-burst and overflow: pulse rst_n low during BURST -> all outputs 0; then fifo_overflow=1 for one cycle -> err_ovf=1 held until the next reset; with FIFO_WR_ARB_STATS_EN, 70000 grants to requester 0 -> grant_cnt[15:0]=16'hFFFF.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Requester and FIFO write-side bundle for fifo_wr_arb.
// master drives requests and FIFO flags; slave is the arbiter.
interface fifo_wr_arb_if #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            last;
   logic [NUM_REQ*FIFO_WIDTH-1:0] data_in;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_full;
   logic                          fifo_overflow;
   logic                          fifo_wr_en;
   logic [FIFO_WIDTH-1:0]         fifo_data_in;

   modport master (
      output req, last, data_in, fifo_full, fifo_overflow,
      input  gnt, fifo_wr_en, fifo_data_in
   );

   modport slave (
      input  req, last, data_in, fifo_full, fifo_overflow,
      output gnt, fifo_wr_en, fifo_data_in
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin burst write arbiter in front of a FIFO.
// Define FIFO_WR_ARB_STATS_EN to build saturating per-requester grant counters.
module fifo_wr_arb #(
   parameter int NUM_REQ    = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int MAX_BURST  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   fifo_wr_arb_if.slave               bus,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   output logic                       err_ovf,
   output logic [NUM_REQ*16-1:0]      grant_cnt
);
   localparam int IW = $clog2(NUM_REQ);
   localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST);
   localparam bit MULTI = (MAX_BURST > 1);

   typedef enum logic {ARB, BURST} state_t;

   state_t          state;
   logic [IW-1:0]   rr_ptr;
   logic [3:0]      beat_cnt;
   logic [IW-1:0]   win;
   logic            win_vld;
   logic [IW-1:0]   sel;
   logic [NUM_REQ-1:0] gnt_c;
   int              idx;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
      return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
   endfunction

   // first requester at or after rr_ptr, wrapping
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_vld && bus.req[idx]) begin
            win_vld = 1'b1;
            win     = idx[IW-1:0];
         end
      end
   end

   always_comb begin
      gnt_c = '0;
      sel   = (state == BURST) ? owner : win;
      if (rst_n && !bus.fifo_full) begin
         if (state == BURST) gnt_c[owner] = bus.req[owner];
         else if (win_vld)   gnt_c[win]   = 1'b1;
      end
   end

   assign bus.gnt          = gnt_c;
   assign bus.fifo_wr_en   = |gnt_c;
   assign bus.fifo_data_in = (|gnt_c) ?
      bus.data_in[sel*FIFO_WIDTH +: FIFO_WIDTH] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ARB;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         owner    <= '0;
         busy     <= 1'b0;
         err_ovf  <= 1'b0;
      end else begin
         if (bus.fifo_overflow) err_ovf <= 1'b1;
         unique case (state)
            ARB: begin
               if (|gnt_c) begin
                  if (!bus.last[win] && MULTI) begin
                     state    <= BURST;
                     busy     <= 1'b1;
                     owner    <= win;
                     beat_cnt <= 4'd1;
                  end else begin
                     rr_ptr <= nxt(win);
                  end
               end
            end
            BURST: begin
               if (!bus.req[owner] ||
                   (gnt_c[owner] &&
                    (bus.last[owner] || beat_cnt + 4'd1 == LAST_BEAT))) begin
                  state    <= ARB;
                  busy     <= 1'b0;
                  beat_cnt <= '0;
                  rr_ptr   <= nxt(owner);
               end else if (gnt_c[owner]) begin
                  beat_cnt <= beat_cnt + 4'd1;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] cnt [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (gnt_c[i] && cnt[i] != 16'hFFFF) cnt[i] <= cnt[i] + 16'd1;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_cnt[g*16 +: 16] = cnt[g];
   end
`else
   assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Randomized bench for fifo_wr_arb against a queue-free arbitration model.
// Directed fairness and burst-cap sequences precede the random run.
module tb_fifo_wr_arb;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0] owner;
   logic busy, err_ovf;
   logic [N*16-1:0] grant_cnt;

   always #5 clk = ~clk;

   fifo_wr_arb_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus ();

   fifo_wr_arb #(.NUM_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .owner     (owner),
      .busy      (busy),
      .err_ovf   (err_ovf),
      .grant_cnt (grant_cnt)
   );

   int vectors = 0;
   int errors  = 0;
   int m_own, m_beats, m_ptr;
   bit m_err;
   int m_cnt [N];
   logic [N-1:0] seen_gnt;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_own   = -1;
      m_beats = 0;
      m_ptr   = 0;
      m_err   = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
   endfunction

   task automatic step(input bit r, input logic [N-1:0] rq,
                       input logic [N-1:0] lt, input bit full,
                       input bit ovf, input logic [N*W-1:0] d);
      logic [N-1:0]  eg;
      logic [63:0]   ecnt;
      logic [W-1:0]  edat;
      int w;
      rst_n             = r;
      bus.req           = rq;
      bus.last          = lt;
      bus.fifo_full     = full;
      bus.fifo_overflow = ovf;
      bus.data_in       = d;
      if (!r) model_reset();
      #4;
      eg = '0;
      w  = -1;
      if (r && !full) begin
         if (m_own >= 0) begin
            if (rq[m_own]) w = m_own;
         end else begin
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (w < 0 && rq[j]) w = j;
            end
         end
      end
      edat = '0;
      if (w >= 0) begin
         eg[w] = 1'b1;
         edat  = d[w*W +: W];
      end
      ecnt = '0;
`ifdef FIFO_WR_ARB_STATS_EN
      for (int i = 0; i < N; i++) ecnt[i*16 +: 16] = 16'(m_cnt[i]);
`endif
      seen_gnt = bus.gnt;
      chk("gnt", bus.gnt, eg);
      chk("wr_en", bus.fifo_wr_en, |eg);
      chk("data", bus.fifo_data_in, edat);
      chk("busy", busy, m_own >= 0);
      if (m_own >= 0) chk("owner", owner, m_own);
      if (!r) chk("owner_rst", owner, 0);
      chk("err_ovf", err_ovf, m_err);
      chk("grant_cnt", grant_cnt, ecnt);
      @(posedge clk);
      #1;
      if (r) begin
         if (ovf) m_err = 1'b1;
         if (w >= 0 && m_cnt[w] < 65535) m_cnt[w]++;
         if (m_own < 0) begin
            if (w >= 0) begin
               if (!lt[w] && MB > 1) begin
                  m_own   = w;
                  m_beats = 1;
               end else begin
                  m_ptr = (w + 1) % N;
               end
            end
         end else if (!rq[m_own]) begin
            m_ptr = (m_own + 1) % N;
            m_own = -1;
         end else if (w >= 0) begin
            m_beats++;
            if (lt[w] || m_beats == MB) begin
               m_ptr = (m_own + 1) % N;
               m_own = -1;
            end
         end
      end
   endtask

   logic [N-1:0] fair_tbl  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [N-1:0] burst_tbl [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};

   initial begin
      logic [N-1:0] rq, lt;
      logic [N*W-1:0] d;
      model_reset();
      step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 64'h1111_2222_3333_4444);
      step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0, 64'hA0A0_B1B1_C2C2_D3D3);
         chk("fair", seen_gnt, fair_tbl[i]);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF);
         chk("burst_cap", seen_gnt, burst_tbl[i]);
      end
      for (int c = 0; c < 3000; c++) begin
         rq = '0;
         lt = '0;
         for (int i = 0; i < N; i++) begin
            rq[i] = ($urandom_range(0, 9) < 7);
            lt[i] = ($urandom_range(0, 9) < 3);
         end
         d = {$urandom, $urandom};
         step(($urandom_range(0, 199) != 0), rq, lt,
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 99) == 0), d);
      end
      step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, '0);
      step(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
      chk("ovf_sticky", err_ovf, 1'b1);
`ifdef FIFO_WR_ARB_STATS_EN
      step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, '0);
      for (int c = 0; c < 70000; c++)
         step(1'b1, 4'b0001, 4'b0001, 1'b0, 1'b0, 64'h5A5A);
      chk("cnt_sat", grant_cnt[15:0], 16'hFFFF);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
